// File: rtl/pipelined_mac_array.sv
// pipelined_mac_array: N-lane unsigned multiply-accumulate, four register stages.
// S1 operand capture, S2 lane products, S3 lane sum, S4 saturating accumulator.
// A beat sampled at edge N is reflected on oValid/oResult after edge N+3.
module pipelined_mac_array #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2,
  parameter int unsigned ACC_W = 20
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic                     iValid,
  input  logic [LANES*WIDTH-1:0]   iA,
  input  logic [LANES*WIDTH-1:0]   iB,
  input  logic                     iAccum,
  input  logic                     iClear,
  output logic                     oValid,
  output logic [ACC_W-1:0]         oResult,
  output logic                     oOverflow
);

  localparam int unsigned PROD_W = 2 * WIDTH;

  // The lane sum must fit the accumulator without wrapping.
  generate
    if (LANES < 1 || ACC_W < 2 * WIDTH + $clog2(LANES)) begin : g_bad_params
      $error("pipelined_mac_array: LANES must be >= 1 and ACC_W >= 2*WIDTH + clog2(LANES)");
    end
  endgenerate

  logic [LANES*WIDTH-1:0] s1_a;
  logic [LANES*WIDTH-1:0] s1_b;
  logic                   s1_valid;
  logic                   s1_accum;

  logic [PROD_W-1:0]      prod_next [LANES];
  logic [PROD_W-1:0]      s2_prod   [LANES];
  logic                   s2_valid;
  logic                   s2_accum;

  logic [ACC_W-1:0]       sum_next;
  logic [ACC_W-1:0]       s3_sum;
  logic                   s3_valid;
  logic                   s3_accum;

  logic [ACC_W:0]         acc_wide;
  logic [ACC_W-1:0]       acc;
  logic                   ovf;
  logic                   out_valid;

  // S1: capture operands and beat qualifiers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_a     <= '0;
      s1_b     <= '0;
      s1_valid <= 1'b0;
      s1_accum <= 1'b0;
    end else begin
      s1_a     <= iA;
      s1_b     <= iB;
      s1_valid <= iValid;
      s1_accum <= iAccum;
    end
  end

  // Per-lane unsigned products, widened before multiplying.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      prod_next[k] = PROD_W'(s1_a[k*WIDTH +: WIDTH]) * PROD_W'(s1_b[k*WIDTH +: WIDTH]);
    end
  end

  // S2: register lane products.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        s2_prod[k] <= '0;
      end
      s2_valid <= 1'b0;
      s2_accum <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        s2_prod[k] <= prod_next[k];
      end
      s2_valid <= s1_valid;
      s2_accum <= s1_accum;
    end
  end

  // Adder tree over all lanes, zero-extended to the accumulator width.
  always_comb begin
    sum_next = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      sum_next = sum_next + ACC_W'(s2_prod[k]);
    end
  end

  // S3: register lane sum.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s3_sum   <= '0;
      s3_valid <= 1'b0;
      s3_accum <= 1'b0;
    end else begin
      s3_sum   <= sum_next;
      s3_valid <= s2_valid;
      s3_accum <= s2_accum;
    end
  end

  // One extra bit exposes the carry used for saturation.
  always_comb begin
    acc_wide = {1'b0, acc} + {1'b0, s3_sum};
  end

  // S4: accumulator with saturation, sticky overflow and synchronous clear.
  // A clear coinciding with a beat zeroes first, so the beat simply loads its sum.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        if (s3_accum && !iClear) begin
          if (acc_wide[ACC_W]) begin
            acc <= '1;
            ovf <= 1'b1;
          end else begin
            acc <= acc_wide[ACC_W-1:0];
          end
        end else begin
          acc <= s3_sum;
          ovf <= 1'b0;
        end
      end else if (iClear) begin
        acc <= '0;
        ovf <= 1'b0;
      end
    end
  end

  assign oValid    = out_valid;
  assign oResult   = acc;
  assign oOverflow = ovf;

endmodule

// File: tb/tb_pipelined_mac_array.sv
// tb_pipelined_mac_array: directed vector table, hand-written corner sequences,
// and random beats checked against a queue-based accumulator model.
module tb_pipelined_mac_array;

  localparam longint unsigned MAX20 = 64'd1048575;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, accum, clear;
  logic [15:0] a, b;
  logic        ov;
  logic [19:0] res;
  logic        ovf;

  logic        rst2_n;
  logic        valid2, accum2, clear2;
  logic [15:0] a2, b2;
  logic        ov2;
  logic [9:0]  res2;
  logic        ovf2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_mac_array #(.WIDTH(8), .LANES(2), .ACC_W(20)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iValid(valid), .iA(a), .iB(b),
    .iAccum(accum), .iClear(clear), .oValid(ov), .oResult(res), .oOverflow(ovf)
  );

  pipelined_mac_array #(.WIDTH(4), .LANES(4), .ACC_W(10)) dut2 (
    .iCLK(clk), .iRST_N(rst2_n), .iValid(valid2), .iA(a2), .iB(b2),
    .iAccum(accum2), .iClear(clear2), .oValid(ov2), .oResult(res2), .oOverflow(ovf2)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned     due;
    bit              acc_mode;
    longint unsigned sum;
  } beat_t;

  beat_t           q[$];
  int unsigned     edge_cnt = 0;
  longint unsigned m_acc = 0;
  bit              m_ovf = 1'b0;
  bit              m_valid = 1'b0;

  function automatic longint unsigned lane_sum(input logic [15:0] x, input logic [15:0] y);
    longint unsigned s = 0;
    for (int k = 0; k < 2; k++) begin
      s += longint'((32'(x) >> (8 * k)) & 32'hFF) * longint'((32'(y) >> (8 * k)) & 32'hFF);
    end
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    m_acc   = 0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic model_edge(input bit v, input bit md, input bit clr,
                            input logic [15:0] x, input logic [15:0] y);
    beat_t nb;
    beat_t cur;
    longint unsigned t;
    m_valid = 1'b0;
    if (clr) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end
    if (q.size() > 0 && q[0].due == edge_cnt) begin
      cur = q.pop_front();
      m_valid = 1'b1;
      if (cur.acc_mode && !clr) begin
        t = m_acc + cur.sum;
        if (t > MAX20) begin
          m_acc = MAX20;
          m_ovf = 1'b1;
        end else begin
          m_acc = t;
        end
      end else begin
        m_acc = cur.sum;
        m_ovf = 1'b0;
      end
    end
    if (v) begin
      nb.due      = edge_cnt + 3;
      nb.acc_mode = md;
      nb.sum      = lane_sum(x, y);
      q.push_back(nb);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit md, input bit clr,
                       input logic [15:0] x, input logic [15:0] y);
    valid = v;
    accum = md;
    clear = clr;
    a     = x;
    b     = y;
  endtask

  // One clock: model sees the inputs sampled at the rising edge; return at the falling edge.
  task automatic tick();
    bit v, md, clr;
    logic [15:0] x, y;
    v = valid; md = accum; clr = clear; x = a; y = b;
    @(posedge clk);
    edge_cnt++;
    if (!rst_n) model_reset();
    else model_edge(v, md, clr, x, y);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v, md, clr;
    logic [15:0] x, y;
    logic        chk;
    logic        e_valid;
    logic [19:0] e_res;
    logic        e_ovf;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic md, input logic clr,
                              input logic [15:0] x, input logic [15:0] y,
                              input logic ev, input logic [19:0] er, input logic eo);
    vec_t r;
    r.v = v; r.md = md; r.clr = clr; r.x = x; r.y = y;
    r.chk = 1'b1; r.e_valid = ev; r.e_res = er; r.e_ovf = eo;
    return r;
  endfunction

  vec_t tbl[33];

  initial begin
    // reset state
    rst_n = 1'b0; rst2_n = 1'b0;
    drive(0, 0, 0, '0, '0);
    valid2 = 0; accum2 = 0; clear2 = 0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", 32'(ov), 32'd0);
    check("reset_result", 32'(res), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset2_result", 32'(res2), 32'd0);
    rst_n = 1'b1; rst2_n = 1'b1;
    model_reset();

    // table: single beat, back-to-back, saturation, clear collision
    tbl[0]  = mk(1, 0, 0, {8'd5, 8'd3}, {8'd6, 8'd4}, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, '0, '0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, '0, '0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, '0, '0, 1, 42, 0);
    tbl[4]  = mk(0, 0, 0, '0, '0, 0, 42, 0);
    tbl[5]  = mk(1, 0, 0, {8'd1, 8'd1}, {8'd1, 8'd1}, 0, 42, 0);
    tbl[6]  = mk(1, 1, 0, {8'd2, 8'd2}, {8'd2, 8'd2}, 0, 42, 0);
    tbl[7]  = mk(1, 1, 0, {8'd3, 8'd3}, {8'd3, 8'd3}, 0, 42, 0);
    tbl[8]  = mk(0, 0, 0, '0, '0, 1, 2, 0);
    tbl[9]  = mk(0, 0, 0, '0, '0, 1, 10, 0);
    tbl[10] = mk(0, 0, 0, '0, '0, 1, 28, 0);
    tbl[11] = mk(0, 0, 0, '0, '0, 0, 28, 0);
    tbl[12] = mk(0, 0, 1, '0, '0, 0, 0, 0);
    for (int i = 13; i <= 21; i++) begin
      if (i <= 15) tbl[i] = mk(1, 1, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0);
      else         tbl[i] = mk(1, 1, 0, 16'hFFFF, 16'hFFFF, 1, 20'(130050 * (i - 15)), 0);
    end
    tbl[22] = mk(1, 0, 0, {8'd0, 8'd1}, {8'd0, 8'd1}, 1, 20'd910350, 0);
    tbl[23] = mk(0, 0, 0, '0, '0, 1, 20'd1040400, 0);
    tbl[24] = mk(0, 0, 0, '0, '0, 1, 20'd1048575, 1);
    tbl[25] = mk(0, 0, 0, '0, '0, 1, 1, 0);
    tbl[26] = mk(1, 0, 0, {8'd5, 8'd3}, {8'd6, 8'd4}, 0, 1, 0);
    tbl[27] = mk(1, 1, 0, {8'd1, 8'd3}, {8'd1, 8'd3}, 0, 1, 0);
    tbl[28] = mk(0, 0, 0, '0, '0, 0, 1, 0);
    tbl[29] = mk(0, 0, 0, '0, '0, 1, 42, 0);
    tbl[30] = mk(0, 0, 1, '0, '0, 1, 10, 0);
    tbl[31] = mk(0, 0, 1, '0, '0, 0, 0, 0);
    tbl[32] = mk(0, 0, 0, '0, '0, 0, 0, 0);

    for (int i = 0; i < 33; i++) begin
      drive(tbl[i].v, tbl[i].md, tbl[i].clr, tbl[i].x, tbl[i].y);
      tick();
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_valid", i), 32'(ov), 32'(tbl[i].e_valid));
        check($sformatf("tbl%0d_result", i), 32'(res), 32'(tbl[i].e_res));
        check($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].e_ovf));
      end
    end

    // reset mid-flight
    drive(1, 0, 0, {8'd5, 8'd3}, {8'd6, 8'd4});
    tick();
    drive(0, 0, 0, '0, '0);
    repeat (3) tick();
    check("pre_reset_result", 32'(res), 32'd42);
    drive(1, 1, 0, {8'd1, 8'd3}, {8'd1, 8'd3});
    tick();
    drive(1, 1, 0, {8'd1, 8'd3}, {8'd1, 8'd3});
    tick();
    drive(1, 1, 0, {8'd1, 8'd3}, {8'd1, 8'd3});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(ov), 32'd0);
    check("async_reset_result", 32'(res), 32'd0);
    check("async_reset_ovf", 32'(ovf), 32'd0);
    drive(0, 0, 0, '0, '0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_reset_no_valid", 32'(ov), 32'd0);
      check("post_reset_result", 32'(res), 32'd0);
    end

    // random beats against the model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        x = x | 16'h8080;
        y = y | 16'h8080;
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 15) == 0, x, y);
      tick();
      check("rand_valid", 32'(ov), 32'(m_valid));
      check("rand_result", 32'(res), 32'(m_acc));
      check("rand_ovf", 32'(ovf), 32'(m_ovf));
    end
    drive(0, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_valid", 32'(ov), 32'(m_valid));
      check("drain_result", 32'(res), 32'(m_acc));
    end

    // alternate generics: WIDTH=4, LANES=4, ACC_W=10
    valid2 = 1; accum2 = 0; a2 = 16'hFFFF; b2 = 16'hFFFF;
    tick();
    valid2 = 1; accum2 = 1;
    tick();
    valid2 = 0; accum2 = 0;
    tick();
    check("g2_no_valid_early", 32'(ov2), 32'd0);
    tick();
    check("g2_valid", 32'(ov2), 32'd1);
    check("g2_result", 32'(res2), 32'd900);
    check("g2_ovf", 32'(ovf2), 32'd0);
    tick();
    check("g2_sat_result", 32'(res2), 32'd1023);
    check("g2_sat_ovf", 32'(ovf2), 32'd1);
    clear2 = 1;
    tick();
    clear2 = 0;
    check("g2_clear_valid", 32'(ov2), 32'd0);
    check("g2_clear_result", 32'(res2), 32'd0);
    check("g2_clear_ovf", 32'(ovf2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
